// File: rtl/fmul_issue_queue_pkg.sv
// Shared constants for the FMUL issue queue: S2E packet geometry, killmask field and default depth.
package fmul_issue_queue_pkg;
  localparam int PORT_S2E_LEN          = 32;
  localparam int SPEC_STATES           = 4;
  localparam int PORT_S2E_KILLMASK_LSB = 8;
  localparam int FMUL_IQ_DEPTH         = 2;

  typedef logic [SPEC_STATES-1:0] spec_mask_t;
endpackage

// File: rtl/fmul_issue_queue_entry.sv
// One issue-queue slot: valid bit plus packet, with its own kill test and resolve-cleared packet view.
module fmul_iq_entry
  import fmul_issue_queue_pkg::*;
#(
  parameter int PKT_LEN = PORT_S2E_LEN,
  parameter int SPEC_W  = SPEC_STATES,
  parameter int KM_LSB  = PORT_S2E_KILLMASK_LSB
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid_i,
  input  logic [PKT_LEN-1:0] wr_pkt_i,
  input  logic               kill_en_i,
  input  logic [SPEC_W-1:0]  kill_mask_i,
  input  logic               resolve_en_i,
  input  logic [SPEC_W-1:0]  resolve_mask_i,
  output logic               valid_o,
  output logic               killed_o,
  output logic [PKT_LEN-1:0] pkt_o
);
  logic               valid_q;
  logic [PKT_LEN-1:0] pkt_q;
  logic [PKT_LEN-1:0] clr_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= wr_valid_i;
  end

  // Packet storage carries no reset; it is meaningless while valid_q is low.
  always_ff @(posedge clk) begin
    pkt_q <= wr_pkt_i;
  end

  always_comb begin
    clr_mask = '0;
    if (resolve_en_i) clr_mask[KM_LSB +: SPEC_W] = resolve_mask_i;
  end

  // Kill test deliberately uses the stored (pre-resolve) killmask.
  assign killed_o = valid_q & kill_en_i & (|(pkt_q[KM_LSB +: SPEC_W] & kill_mask_i));
  assign valid_o  = valid_q;
  assign pkt_o    = pkt_q & ~clr_mask;
endmodule

// File: rtl/fmul_issue_queue.sv
// In-order, killmask-aware issue buffer in front of FMUL with shift-compacting storage.
// Optional zero-latency bypass when FMUL_ISSUE_QUEUE_BYPASS_EN is defined.
module fmul_issue_queue
  import fmul_issue_queue_pkg::*;
#(
  parameter int DEPTH   = FMUL_IQ_DEPTH,
  parameter int PKT_LEN = PORT_S2E_LEN,
  parameter int SPEC_W  = SPEC_STATES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Flush,
  input  logic                       Kill_Enable,
  input  logic [SPEC_W-1:0]          Kill_VKillMask,
  input  logic                       Resolve_Enable,
  input  logic [SPEC_W-1:0]          Resolve_Mask,
  input  logic                       In_Valid,
  input  logic [PKT_LEN-1:0]         In_S2E,
  output logic                       In_Ready,
  output logic                       Port_Valid,
  output logic [PKT_LEN-1:0]         Port_S2E,
  input  logic                       FU_Ready,
  output logic [$clog2(DEPTH):0]     Occupancy
);
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int KM_LSB = PORT_S2E_KILLMASK_LSB;

  logic [DEPTH-1:0]   ent_valid, ent_killed, slot_valid_d;
  logic [PKT_LEN-1:0] ent_pkt     [DEPTH];
  logic [PKT_LEN-1:0] slot_pkt_d  [DEPTH];
  logic [PKT_LEN-1:0] cand_pkt    [DEPTH+1];
  logic [CW-1:0]      pos         [DEPTH+1];
  logic [DEPTH:0]     surv;
  logic [CW-1:0]      occ_q, occ_d;
  logic [PKT_LEN-1:0] in_clr, in_pkt_res;
  logic               in_killed, bypass_sel, head_pv, pop, pop_head, enq;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      fmul_iq_entry #(.PKT_LEN(PKT_LEN), .SPEC_W(SPEC_W), .KM_LSB(KM_LSB)) u_entry (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid_i    (slot_valid_d[gi]),
        .wr_pkt_i      (slot_pkt_d[gi]),
        .kill_en_i     (Kill_Enable),
        .kill_mask_i   (Kill_VKillMask),
        .resolve_en_i  (Resolve_Enable),
        .resolve_mask_i(Resolve_Mask),
        .valid_o       (ent_valid[gi]),
        .killed_o      (ent_killed[gi]),
        .pkt_o         (ent_pkt[gi])
      );
      assign cand_pkt[gi] = ent_pkt[gi];
      assign surv[gi]     = ent_valid[gi] & ~ent_killed[gi] & ~Flush & ~(pop_head & (gi == 0));
    end
  endgenerate

  always_comb begin
    in_clr = '0;
    if (Resolve_Enable) in_clr[KM_LSB +: SPEC_W] = Resolve_Mask;
  end

  assign in_pkt_res      = In_S2E & ~in_clr;
  assign cand_pkt[DEPTH] = in_pkt_res;
  assign in_killed       = Kill_Enable & (|(In_S2E[KM_LSB +: SPEC_W] & Kill_VKillMask));
  assign head_pv         = ent_valid[0] & ~ent_killed[0] & ~Flush;

`ifdef FMUL_ISSUE_QUEUE_BYPASS_EN
  // Bypass only when no older live entry exists, so issue order is preserved.
  assign bypass_sel = In_Valid & ~(|(ent_valid & ~ent_killed));
`else
  assign bypass_sel = 1'b0;
`endif

  assign Port_Valid = bypass_sel ? (~in_killed & ~Flush) : head_pv;
  assign Port_S2E   = bypass_sel ? in_pkt_res : ent_pkt[0];
  assign pop        = Port_Valid & FU_Ready;
  assign pop_head   = pop & ~bypass_sel;
  assign In_Ready   = (occ_q < CW'(DEPTH)) | pop;
  assign enq        = In_Valid & In_Ready;
  assign surv[DEPTH] = enq & ~in_killed & ~Flush & ~(bypass_sel & pop);

  // Candidates are in age order (entries then incoming); slot k takes the k-th survivor.
  always_comb begin
    pos[0] = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      pos[i] = pos[i-1] + {{(CW-1){1'b0}}, surv[i-1]};
    end
    for (int k = 0; k < DEPTH; k++) begin
      slot_valid_d[k] = 1'b0;
      slot_pkt_d[k]   = cand_pkt[k];
      for (int i = 0; i <= DEPTH; i++) begin
        if (surv[i] && (pos[i] == CW'(k))) begin
          slot_valid_d[k] = 1'b1;
          slot_pkt_d[k]   = cand_pkt[i];
        end
      end
    end
    occ_d = pos[DEPTH] + {{(CW-1){1'b0}}, surv[DEPTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign Occupancy = occ_q;
endmodule
